dcache_ctrl: RTL

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl_pkg.sv | 25 ++
 rtl/dcache_sram.sv | 59 +++++
 rtl/dcache_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller:
// FSM state encoding, line geometry and address-split width helpers.
package dcache_ctrl_pkg;

  localparam int ADDR_W    = 32;
  localparam int WORD_W    = 32;
  localparam int LINE_BITS = 256;
  localparam int OFFSET_W  = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_WB_REQ  = 2'd1;
  localparam state_t ST_RF_REQ  = 2'd2;
  localparam state_t ST_RF_DONE = 2'd3;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines);
    return ADDR_W - OFFSET_W - idx_w(lines);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache: one port, combinational
// read at idx_i, synchronous write. Only valid/dirty bits are reset.
module dcache_sram #(
  parameter int LINES     = 16,
  parameter int TAG_W     = 23,
  parameter int LINE_BITS = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [$clog2(LINES)-1:0] idx_i,
  input  logic                     we_i,
  input  logic                     wr_valid_i,
  input  logic                     wr_dirty_i,
  input  logic [TAG_W-1:0]         wr_tag_i,
  input  logic [LINE_BITS-1:0]     wr_data_i,
  output logic                     rd_valid_o,
  output logic                     rd_dirty_o,
  output logic [TAG_W-1:0]         rd_tag_o,
  output logic [LINE_BITS-1:0]     rd_data_o
);

  logic [LINES-1:0]     valid_q, valid_d;
  logic [LINES-1:0]     dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (we_i) begin
      valid_d[idx_i] = wr_valid_i;
      dirty_d[idx_i] = wr_dirty_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; a cleared valid bit masks them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[idx_i]  <= wr_tag_i;
      data_q[idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_data_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with a
// combinational hit path and a four-state miss FSM (write-back, refill).
module dcache_ctrl #(
  parameter int LINES     = 16,
  parameter int LINE_BITS = dcache_ctrl_pkg::LINE_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i,
  output logic [1:0]           dbg_state_o
);
  import dcache_ctrl_pkg::*;

  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  = tag_w(LINES);
  localparam int WORDS  = LINE_BITS / WORD_W;
  localparam int WSEL_W = $clog2(WORDS);

  // Handshake: mem_req_o with mem_we_o/mem_addr_o/mem_wdata_o is held stable
  // until the one-cycle mem_ack_i pulse; the request drops (or moves on to the
  // next request) on the cycle after the ack.

  state_t state_q, state_d;

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [WSEL_W-1:0]    wsel;
  logic                 unused_addr_lsb;

  logic                 rd_valid, rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic [31:0]          rd_word;
  logic [LINE_BITS-1:0] st_line;

  logic                 sram_we;
  logic                 wr_dirty;
  logic [LINE_BITS-1:0] wr_data;
  logic                 hit;

  assign idx             = cpu_addr_i[OFFSET_W +: IDX_W];
  assign tag             = cpu_addr_i[31 -: TAG_W];
  assign wsel            = cpu_addr_i[2 +: WSEL_W];
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  dcache_sram #(
    .LINES     (LINES),
    .TAG_W     (TAG_W),
    .LINE_BITS (LINE_BITS)
  ) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx_i      (idx),
    .we_i       (sram_we),
    .wr_valid_i (1'b1),
    .wr_dirty_i (wr_dirty),
    .wr_tag_i   (tag),
    .wr_data_i  (wr_data),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data)
  );

  assign hit = cpu_req_i && (state_q == ST_IDLE) && rd_valid && (rd_tag == tag);

  always_comb begin
    rd_word = rd_data[wsel*WORD_W +: WORD_W];
    st_line = rd_data;
    st_line[wsel*WORD_W +: WORD_W] = cpu_wdata_i;
  end

  assign cpu_rdata_o = hit ? rd_word : 32'd0;
  // Gated by reset so an access presented while reset is held never stalls.
  assign cpu_stall_o = rst_i && cpu_req_i && !hit;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d  = state_q;
    sram_we  = 1'b0;
    wr_dirty = 1'b0;
    wr_data  = mem_rdata_i;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            if (cpu_we_i) begin
              sram_we  = 1'b1;
              wr_dirty = 1'b1;
              wr_data  = st_line;
            end
          end else if (rd_valid && rd_dirty) begin
            state_d = ST_WB_REQ;
          end else begin
            state_d = ST_RF_REQ;
          end
        end
      end
      ST_WB_REQ: begin
        if (mem_ack_i) state_d = ST_RF_REQ;
      end
      ST_RF_REQ: begin
        if (mem_ack_i) begin
          sram_we = 1'b1;
          state_d = ST_RF_DONE;
        end
      end
      ST_RF_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = '0;
    case (state_q)
      ST_WB_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {rd_tag, idx, {OFFSET_W{1'b0}}};
        mem_wdata_o = rd_data;
      end
      ST_RF_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {tag, idx, {OFFSET_W{1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

endmodule
